intc_cpu_responder: RTL and testbench

//  CPU-side responder for the intc IRQ/IACK handshake. It samples irq at instruction

---
 rtl/intc_cpu_responder_if.sv | 37 +++
 rtl/intc_cpu_responder.sv | 152 +++++++++++++++
 tb/tb_intc_cpu_responder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intc_cpu_responder_if.sv
// intc_cpu_responder_if
//  Bundles the signals between the CPU-side interrupt responder and its neighbours:
//   - intc handshake: irq, isr_addr, priority_select (to responder), iack (from responder)
//   - retire/fetch:   instr_done, next_pc, mret (to responder),
//                     redirect_valid, redirect_pc, in_isr, overrun (from responder)
//   - register bus:   input_addr, write_data, write_enable (to responder),
//                     read_data (from responder)
//  The slave modport is the responder's view; master is the environment's view.
interface intc_cpu_responder_if;
  logic        irq;
  logic [31:0] isr_addr;
  logic [1:0]  priority_select;
  logic        iack;
  logic        instr_done;
  logic [31:0] next_pc;
  logic        mret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        in_isr;
  logic        overrun;
  logic [31:0] input_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data;

  modport slave (
    input  irq, isr_addr, priority_select, instr_done, next_pc, mret,
           input_addr, write_data, write_enable,
    output iack, redirect_valid, redirect_pc, in_isr, overrun, read_data
  );

  modport master (
    output irq, isr_addr, priority_select, instr_done, next_pc, mret,
           input_addr, write_data, write_enable,
    input  iack, redirect_valid, redirect_pc, in_isr, overrun, read_data
  );
endinterface

// File: rtl/intc_cpu_responder.sv
// intc_cpu_responder
//  CPU-side responder for the intc IRQ/IACK handshake. At an instruction boundary
//  with gie set it latches the ISR vector, source index and return PC, pulses iack
//  for one cycle while redirecting fetch to the ISR, masks nesting until MRET
//  retires, then redirects back to the saved PC. A watchdog flags handlers that
//  run too long, and a 4-word register window exposes CTRL/STATUS/EPC/COUNT.
// Ports
//  clk   in  system clock, rising edge
//  rst   in  synchronous active-high reset
//  bus   slave modport of intc_cpu_responder_if (handshake, retire/fetch, register bus)
// Parameters
//  BASE_ADDR  base byte address of the register window
//  WD_LIMIT   watchdog threshold in ISR cycles (1..65535)
module intc_cpu_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF40,
  parameter int unsigned WD_LIMIT  = 16
) (
  input logic                  clk,
  input logic                  rst,
  intc_cpu_responder_if.slave  bus
);

  localparam logic [15:0] WD_MAX = 16'(WD_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    ISR  = 2'd2,
    RET  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] vec;
  logic [31:0] epc;
  logic [1:0]  src;
  logic [15:0] isr_count;
  logic [15:0] wd_count;
  logic        gie;
  logic        overrun_q;
  logic        accept;
  logic        wd_hit;
  logic        ctrl_wr;
  logic        in_isr_w;
  logic        unused_wdata;

  // An interrupt is taken only in IDLE at a retiring boundary with the current
  // (pre-write) gie; the watchdog "hit" is the edge where the count reaches WD_LIMIT.
  assign accept       = (state == IDLE) && bus.irq && gie && bus.instr_done;
  assign wd_hit       = (state == ISR) && (wd_count == WD_MAX - 16'd1);
  assign ctrl_wr      = bus.write_enable && (bus.input_addr == BASE_ADDR);
  assign unused_wdata = ^bus.write_data[31:2];

  // State register: reset always lands in IDLE regardless of where we were.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ACK and RET are single-cycle, ISR waits for a retiring MRET,
  // and irq is ignored everywhere except IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = ACK;
      ACK:  state_next = ISR;
      ISR:  if (bus.instr_done && bus.mret) state_next = RET;
      RET:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/fetch outputs decode from state, but are forced low during a reset
  // cycle so no iack or redirect escapes while the FSM is being torn down.
  always_comb begin
    bus.iack           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    in_isr_w           = 1'b0;
    if (!rst) begin
      case (state)
        ACK: begin
          bus.iack           = 1'b1;
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = vec;
        end
        ISR: in_isr_w = 1'b1;
        RET: begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = epc;
          in_isr_w           = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_isr  = in_isr_w;
  assign bus.overrun = overrun_q;

  // Datapath: latch the request on acceptance, count serviced interrupts in ACK,
  // run the watchdog while in ISR, and apply CTRL writes. A watchdog hit wins over
  // a same-cycle software clear so an overrun is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= 32'h0;
      epc       <= 32'h0;
      src       <= 2'b0;
      isr_count <= 16'h0;
      wd_count  <= 16'h0;
      gie       <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        vec      <= bus.isr_addr;
        src      <= bus.priority_select;
        epc      <= bus.next_pc;
        wd_count <= 16'h0;
      end
      if ((state == ACK) && (isr_count != 16'hFFFF)) begin
        isr_count <= isr_count + 16'd1;
      end
      if ((state == ISR) && (wd_count != WD_MAX)) begin
        wd_count <= wd_count + 16'd1;
      end
      if (ctrl_wr) begin
        gie <= bus.write_data[0];
      end
      if (wd_hit) begin
        overrun_q <= 1'b1;
      end else if (ctrl_wr && bus.write_data[1]) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Register window read mux; anything outside the four words reads as zero.
  always_comb begin
    bus.read_data = 32'h0;
    case (bus.input_addr)
      BASE_ADDR:           bus.read_data = {31'h0, gie};
      BASE_ADDR + 32'h4:   bus.read_data = {28'h0, overrun_q, src, in_isr_w};
      BASE_ADDR + 32'h8:   bus.read_data = epc;
      BASE_ADDR + 32'hC:   bus.read_data = {16'h0, isr_count};
      default:             bus.read_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_intc_cpu_responder.sv
// tb_intc_cpu_responder
//  Directed bench for intc_cpu_responder: reset state, IRQ entry/exit, masking,
//  gie gating and write timing, watchdog overrun and its clear, reset mid-handler,
//  and COUNT saturation plus register window decode.
module tb_intc_cpu_responder;

  localparam logic [31:0] BASE = 32'h0000_FF40;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  intc_cpu_responder_if bus ();

  intc_cpu_responder #(
    .BASE_ADDR (BASE),
    .WD_LIMIT  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock; inputs change and outputs are sampled 1ns after posedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic irq, input logic [31:0] isr_addr,
                               input logic [1:0] prio, input logic instr_done,
                               input logic [31:0] next_pc, input logic mret);
    bus.irq             = irq;
    bus.isr_addr        = isr_addr;
    bus.priority_select = prio;
    bus.instr_done      = instr_done;
    bus.next_pc         = next_pc;
    bus.mret            = mret;
    #1;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.input_addr = addr;
    #1;
    checkOutput(tag, bus.read_data, exp);
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    bus.input_addr   = addr;
    bus.write_data   = data;
    bus.write_enable = 1'b1;
    step(1);
    bus.write_enable = 1'b0;
  endtask

  // Full handshake from IDLE through ISR and RET back to IDLE.
  task automatic serviceOne(input logic [31:0] vec, input logic [31:0] pc);
    applyStimulus(1'b1, vec, 2'd1, 1'b1, pc, 1'b0);
    step(1);
    checkOutput("svc_iack", {31'h0, bus.iack}, 32'h1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b1);
    step(1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    bus.irq             = 1'b0;
    bus.isr_addr        = 32'h0;
    bus.priority_select = 2'd0;
    bus.instr_done      = 1'b0;
    bus.next_pc         = 32'h0;
    bus.mret            = 1'b0;
    bus.input_addr      = 32'h0;
    bus.write_data      = 32'h0;
    bus.write_enable    = 1'b0;
    step(2);
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_iack", {31'h0, bus.iack}, 32'h0);
    checkOutput("rst_redir", {31'h0, bus.redirect_valid}, 32'h0);
    checkOutput("rst_in_isr", {31'h0, bus.in_isr}, 32'h0);
    checkOutput("rst_overrun", {31'h0, bus.overrun}, 32'h0);
    readCheck("rst_ctrl", BASE, 32'h0);
    readCheck("rst_status", BASE + 32'h4, 32'h0);
    readCheck("rst_epc", BASE + 32'h8, 32'h0);
    readCheck("rst_count", BASE + 32'hC, 32'h0);

    // Entry: boundary with irq gives iack + redirect next cycle
    busWrite(BASE, 32'h1);
    readCheck("t1_ctrl", BASE, 32'h1);
    applyStimulus(1'b1, 32'h200, 2'd2, 1'b1, 32'h44, 1'b0);
    checkOutput("t1_idle_iack", {31'h0, bus.iack}, 32'h0);
    step(1);
    applyStimulus(1'b1, 32'h300, 2'd1, 1'b0, 32'h88, 1'b0);
    checkOutput("t1_ack_iack", {31'h0, bus.iack}, 32'h1);
    checkOutput("t1_ack_redir", {31'h0, bus.redirect_valid}, 32'h1);
    checkOutput("t1_ack_pc", bus.redirect_pc, 32'h200);
    step(1);
    checkOutput("t1_isr_iack", {31'h0, bus.iack}, 32'h0);
    checkOutput("t1_isr_redir", {31'h0, bus.redirect_valid}, 32'h0);
    checkOutput("t1_isr_in_isr", {31'h0, bus.in_isr}, 32'h1);
    readCheck("t1_status", BASE + 32'h4, 32'h5);
    readCheck("t1_epc", BASE + 32'h8, 32'h44);
    readCheck("t1_count", BASE + 32'hC, 32'h1);

    // Nesting masked: irq held and boundaries retire, but no iack in ISR
    applyStimulus(1'b1, 32'h300, 2'd1, 1'b1, 32'h88, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1);
      checkOutput("t2_masked_iack", {31'h0, bus.iack}, 32'h0);
    end

    // MRET -> RET redirects to saved PC; held irq accepted only after RET
    applyStimulus(1'b1, 32'h300, 2'd1, 1'b1, 32'h88, 1'b1);
    step(1);
    applyStimulus(1'b1, 32'h300, 2'd1, 1'b1, 32'h88, 1'b0);
    checkOutput("t2_ret_redir", {31'h0, bus.redirect_valid}, 32'h1);
    checkOutput("t2_ret_pc", bus.redirect_pc, 32'h44);
    checkOutput("t2_ret_iack", {31'h0, bus.iack}, 32'h0);
    checkOutput("t2_ret_in_isr", {31'h0, bus.in_isr}, 32'h1);
    step(1);
    checkOutput("t2_idle_iack", {31'h0, bus.iack}, 32'h0);
    checkOutput("t2_idle_redir", {31'h0, bus.redirect_valid}, 32'h0);
    step(1);
    checkOutput("t2_second_iack", {31'h0, bus.iack}, 32'h1);
    checkOutput("t2_second_pc", bus.redirect_pc, 32'h300);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);
    readCheck("t2_status", BASE + 32'h4, 32'h3);
    readCheck("t2_epc", BASE + 32'h8, 32'h88);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b1);
    step(1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);
    readCheck("t2_count", BASE + 32'hC, 32'h2);

    // gie=0 blocks acceptance; enabling write is not seen by same-cycle decision
    busWrite(BASE, 32'h0);
    applyStimulus(1'b1, 32'h400, 2'd3, 1'b1, 32'hC0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("t3_gated_iack", {31'h0, bus.iack}, 32'h0);
      step(1);
    end
    bus.input_addr   = BASE;
    bus.write_data   = 32'h1;
    bus.write_enable = 1'b1;
    #1;
    checkOutput("t3_wr_cycle_iack", {31'h0, bus.iack}, 32'h0);
    step(1);
    bus.write_enable = 1'b0;
    checkOutput("t3_post_wr_iack", {31'h0, bus.iack}, 32'h0);
    step(1);
    checkOutput("t3_accept_iack", {31'h0, bus.iack}, 32'h1);
    checkOutput("t3_accept_pc", bus.redirect_pc, 32'h400);

    // Watchdog: overrun sets on the 16th ISR cycle, sticky, cleared by CTRL bit1
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);
    step(15);
    checkOutput("t4_wd15_overrun", {31'h0, bus.overrun}, 32'h0);
    step(1);
    checkOutput("t4_wd16_overrun", {31'h0, bus.overrun}, 32'h1);
    step(4);
    checkOutput("t4_wd20_overrun", {31'h0, bus.overrun}, 32'h1);
    readCheck("t4_status", BASE + 32'h4, 32'hF);
    busWrite(BASE, 32'h3);
    checkOutput("t4_clr_overrun", {31'h0, bus.overrun}, 32'h0);
    readCheck("t4_clr_ctrl", BASE, 32'h1);
    step(2);
    checkOutput("t4_stays_clear", {31'h0, bus.overrun}, 32'h0);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b1);
    step(1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);

    // Clear in the same cycle the watchdog reaches its limit: overrun stays set
    applyStimulus(1'b1, 32'h500, 2'd0, 1'b1, 32'hD0, 1'b0);
    step(1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);
    step(15);
    checkOutput("t4_race_pre", {31'h0, bus.overrun}, 32'h0);
    busWrite(BASE, 32'h3);
    checkOutput("t4_race_overrun", {31'h0, bus.overrun}, 32'h1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b1);
    step(1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);

    // Reset while in ACK
    applyStimulus(1'b1, 32'h600, 2'd2, 1'b1, 32'hE0, 1'b0);
    step(1);
    checkOutput("t5_ack_iack", {31'h0, bus.iack}, 32'h1);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    checkOutput("t5_rstcyc_iack", {31'h0, bus.iack}, 32'h0);
    checkOutput("t5_rstcyc_redir", {31'h0, bus.redirect_valid}, 32'h0);
    step(1);
    rst = 1'b0;
    #1;
    checkOutput("t5_ack_after_iack", {31'h0, bus.iack}, 32'h0);
    checkOutput("t5_ack_after_redir", {31'h0, bus.redirect_valid}, 32'h0);
    checkOutput("t5_ack_after_overrun", {31'h0, bus.overrun}, 32'h0);
    readCheck("t5_ack_count", BASE + 32'hC, 32'h0);
    readCheck("t5_ack_ctrl", BASE, 32'h0);
    step(1);
    checkOutput("t5_no_late_iack", {31'h0, bus.iack}, 32'h0);

    // Reset while in ISR
    busWrite(BASE, 32'h1);
    applyStimulus(1'b1, 32'h700, 2'd3, 1'b1, 32'hF0, 1'b0);
    step(1);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1);
    checkOutput("t5_isr_in_isr", {31'h0, bus.in_isr}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("t5_rstcyc_in_isr", {31'h0, bus.in_isr}, 32'h0);
    step(1);
    rst = 1'b0;
    #1;
    checkOutput("t5_isr_after_in_isr", {31'h0, bus.in_isr}, 32'h0);
    readCheck("t5_isr_epc", BASE + 32'h8, 32'h0);
    readCheck("t5_isr_status", BASE + 32'h4, 32'h0);

    // MRET in IDLE is ignored
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b1);
    checkOutput("t5_idle_mret_redir", {31'h0, bus.redirect_valid}, 32'h0);
    step(1);
    checkOutput("t5_idle_mret_redir2", {31'h0, bus.redirect_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);

    // COUNT saturation and register window decode
    busWrite(BASE, 32'h1);
    force dut.isr_count = 16'hFFFE;
    #1;
    release dut.isr_count;
    readCheck("t6_count_preset", BASE + 32'hC, 32'hFFFE);
    serviceOne(32'h800, 32'h100);
    readCheck("t6_count_max", BASE + 32'hC, 32'hFFFF);
    serviceOne(32'h900, 32'h104);
    readCheck("t6_count_sat", BASE + 32'hC, 32'hFFFF);
    readCheck("t6_epc_last", BASE + 32'h8, 32'h104);
    busWrite(BASE + 32'h8, 32'hDEAD_BEEF);
    readCheck("t6_epc_ro", BASE + 32'h8, 32'h104);
    readCheck("t6_unmapped_hi", BASE + 32'h10, 32'h0);
    readCheck("t6_unmapped_lo", BASE - 32'h4, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
